ball_centroid_acc: RTL and testbench

Downstream consumer of the per-pixel colour-match bit. Receives one match bit per active pixel in raster order and tracks the pixel position internally. Over each frame it accumulates the sum of X, the sum of Y and the count of matching pixels. At end of frame it runs a sequential divider and reports the ball centroid in pixel coordinates, with a found flag and a one-cycle result strobe.

---
 rtl/ball_centroid_acc.sv | 212 +++++++++++++++++++++
 tb/tb_ball_centroid_acc.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ball_centroid_acc.sv
// ball_centroid_acc: accumulates sum of X, sum of Y and the match count of
// colour-matched pixels over each frame, then divides at end of frame to
// report the ball centroid.
//
// Ports:
//   clk_100M     in   system clock, rising edge
//   rst_p        in   asynchronous active-high reset
//   pix_valid    in   one active pixel this cycle
//   pix_match    in   colour-match bit for that pixel
//   sof          in   start of frame, qualified by pix_valid; pixel (0,0)
//   ball_x       out  centroid X, floor(sum_x/count)
//   ball_y       out  centroid Y, floor(sum_y/count)
//   ball_found   out  last completed frame had count >= MIN_PIXELS
//   result_valid out  one-cycle strobe when results update
//   busy         out  divider running
module ball_centroid_acc #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned MIN_PIXELS = 16,
  localparam int unsigned XW  = $clog2(H_ACTIVE),
  localparam int unsigned YW  = $clog2(V_ACTIVE)
) (
  input  logic          clk_100M,
  input  logic          rst_p,
  input  logic          pix_valid,
  input  logic          pix_match,
  input  logic          sof,
  output logic [XW-1:0] ball_x,
  output logic [YW-1:0] ball_y,
  output logic          ball_found,
  output logic          result_valid,
  output logic          busy
);

  localparam int unsigned CW         = $clog2(H_ACTIVE * V_ACTIVE + 1);
  localparam int unsigned SXW        = XW + CW;
  localparam int unsigned SYW        = YW + CW;
  localparam int unsigned DIV_CYCLES = (SXW > SYW) ? SXW : SYW;
  localparam int unsigned DW         = DIV_CYCLES;
  localparam int unsigned ICW        = $clog2(DIV_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic [SXW-1:0]  sum_x_q, sum_x_d;
  logic [SYW-1:0]  sum_y_q, sum_y_d;
  logic [CW-1:0]   count_q, count_d;
  // Dividends shift left into quotients as the division proceeds.
  logic [DW-1:0]   dvd_x_q, dvd_x_d;
  logic [DW-1:0]   dvd_y_q, dvd_y_d;
  logic [CW-1:0]   divisor_q, divisor_d;
  logic [CW-1:0]   rem_x_q, rem_x_d;
  logic [CW-1:0]   rem_y_q, rem_y_d;
  logic [ICW-1:0]  iter_q, iter_d;
  logic [XW-1:0]   ball_x_q, ball_x_d;
  logic [YW-1:0]   ball_y_q, ball_y_d;
  logic            found_q, found_d;
  logic            rvalid_q, rvalid_d;
  logic            busy_q, busy_d;

  // Per-pixel combinational terms
  logic            sof_v, add, last;
  logic [XW-1:0]   cur_x;
  logic [YW-1:0]   cur_y;
  logic [SXW-1:0]  tot_x;
  logic [SYW-1:0]  tot_y;
  logic [CW-1:0]   tot_c;
  logic [CW:0]     sh_x, sh_y;

  // Current pixel position and its contribution to the frame totals.
  always_comb begin
    sof_v = pix_valid && sof;
    add   = pix_valid && pix_match;
    cur_x = sof_v ? '0 : x_q;
    cur_y = sof_v ? '0 : y_q;
    last  = pix_valid && (cur_x == XW'(H_ACTIVE - 1)) && (cur_y == YW'(V_ACTIVE - 1));
    tot_x = (sof_v ? '0 : sum_x_q) + (add ? SXW'(cur_x) : '0);
    tot_y = (sof_v ? '0 : sum_y_q) + (add ? SYW'(cur_y) : '0);
    tot_c = (sof_v ? '0 : count_q) + (add ? CW'(1) : '0);
    // Restoring-division partial remainders: shift in the next dividend bit.
    sh_x  = {rem_x_q, dvd_x_q[DW-1]};
    sh_y  = {rem_y_q, dvd_y_q[DW-1]};
  end

  // Next-state and datapath logic.
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    sum_x_d   = sum_x_q;
    sum_y_d   = sum_y_q;
    count_d   = count_q;
    dvd_x_d   = dvd_x_q;
    dvd_y_d   = dvd_y_q;
    divisor_d = divisor_q;
    rem_x_d   = rem_x_q;
    rem_y_d   = rem_y_q;
    iter_d    = iter_q;
    ball_x_d  = ball_x_q;
    ball_y_d  = ball_y_q;
    found_d   = found_q;
    rvalid_d  = 1'b0;

    if (pix_valid) begin
      if (cur_x == XW'(H_ACTIVE - 1)) begin
        x_d = '0;
        y_d = (cur_y == YW'(V_ACTIVE - 1)) ? '0 : YW'(cur_y + YW'(1));
      end else begin
        x_d = XW'(cur_x + XW'(1));
        y_d = cur_y;
      end
      sum_x_d = last ? '0 : tot_x;
      sum_y_d = last ? '0 : tot_y;
      count_d = last ? '0 : tot_c;
    end

    case (state_q)
      S_IDLE: begin
        if (last) begin
          dvd_x_d   = DW'(tot_x);
          dvd_y_d   = DW'(tot_y);
          divisor_d = tot_c;
          rem_x_d   = '0;
          rem_y_d   = '0;
          iter_d    = '0;
          state_d   = S_DIV;
        end
      end
      S_DIV: begin
        if (sh_x >= {1'b0, divisor_q}) begin
          rem_x_d = CW'(sh_x - {1'b0, divisor_q});
          dvd_x_d = {dvd_x_q[DW-2:0], 1'b1};
        end else begin
          rem_x_d = CW'(sh_x);
          dvd_x_d = {dvd_x_q[DW-2:0], 1'b0};
        end
        if (sh_y >= {1'b0, divisor_q}) begin
          rem_y_d = CW'(sh_y - {1'b0, divisor_q});
          dvd_y_d = {dvd_y_q[DW-2:0], 1'b1};
        end else begin
          rem_y_d = CW'(sh_y);
          dvd_y_d = {dvd_y_q[DW-2:0], 1'b0};
        end
        iter_d = ICW'(iter_q + ICW'(1));
        if (iter_q == ICW'(DIV_CYCLES - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        state_d  = S_IDLE;
        rvalid_d = 1'b1;
        found_d  = 32'(divisor_q) >= MIN_PIXELS;
        // A failed detection (including count 0) keeps the previous centroid.
        if (32'(divisor_q) >= MIN_PIXELS) begin
          ball_x_d = XW'(dvd_x_q);
          ball_y_d = YW'(dvd_y_q);
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_DIV);
  end

  // State and datapath registers.
  always_ff @(posedge clk_100M or posedge rst_p) begin
    if (rst_p) begin
      state_q   <= S_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      sum_x_q   <= '0;
      sum_y_q   <= '0;
      count_q   <= '0;
      dvd_x_q   <= '0;
      dvd_y_q   <= '0;
      divisor_q <= '0;
      rem_x_q   <= '0;
      rem_y_q   <= '0;
      iter_q    <= '0;
      ball_x_q  <= '0;
      ball_y_q  <= '0;
      found_q   <= 1'b0;
      rvalid_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      sum_x_q   <= sum_x_d;
      sum_y_q   <= sum_y_d;
      count_q   <= count_d;
      dvd_x_q   <= dvd_x_d;
      dvd_y_q   <= dvd_y_d;
      divisor_q <= divisor_d;
      rem_x_q   <= rem_x_d;
      rem_y_q   <= rem_y_d;
      iter_q    <= iter_d;
      ball_x_q  <= ball_x_d;
      ball_y_q  <= ball_y_d;
      found_q   <= found_d;
      rvalid_q  <= rvalid_d;
      busy_q    <= busy_d;
    end
  end

  assign ball_x       = ball_x_q;
  assign ball_y       = ball_y_q;
  assign ball_found   = found_q;
  assign result_valid = rvalid_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_ball_centroid_acc.sv
// Testbench for ball_centroid_acc with an 8x6 frame and MIN_PIXELS=2.
module tb_ball_centroid_acc;

  localparam int H    = 8;
  localparam int V    = 6;
  localparam int MINP = 2;
  localparam int NPIX = H * V;
  localparam int LAT  = 11;
  localparam int DIVC = 9;

  logic       clk = 1'b0;
  logic       rst, pv, pm, sof;
  logic [2:0] bx, by;
  logic       bf, rv, busy;

  int tests = 0;
  int fails = 0;
  int exp_x = 0;
  int exp_y = 0;
  int exp_f = 0;

  always #5 clk = ~clk;

  ball_centroid_acc #(.H_ACTIVE(H), .V_ACTIVE(V), .MIN_PIXELS(MINP)) dut (
    .clk_100M(clk), .rst_p(rst), .pix_valid(pv), .pix_match(pm), .sof(sof),
    .ball_x(bx), .ball_y(by), .ball_found(bf), .result_valid(rv), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Reference: centroid of the set bits of a raster-ordered match mask.
  task automatic model(input bit [NPIX-1:0] mask);
    int sx, sy, cnt;
    sx = 0; sy = 0; cnt = 0;
    for (int i = 0; i < NPIX; i++) begin
      if (mask[i]) begin
        sx += i % H;
        sy += i / H;
        cnt++;
      end
    end
    exp_f = (cnt >= MINP) ? 1 : 0;
    if (exp_f == 1) begin
      exp_x = sx / cnt;
      exp_y = sy / cnt;
    end
  endtask

  // Send the first n pixels of a frame starting with sof; optional idle
  // gaps carry pix_match=1 which must be ignored.
  task automatic send_pixels(input bit [NPIX-1:0] mask, input int n, input bit gap);
    for (int i = 0; i < n; i++) begin
      if (gap && i > 0) begin
        @(negedge clk);
        pv = 1'b0; pm = 1'b1; sof = 1'b0;
      end
      @(negedge clk);
      pv = 1'b1; sof = (i == 0); pm = mask[i];
    end
  endtask

  task automatic idle_inputs();
    pv = 1'b0; pm = 1'b0; sof = 1'b0;
  endtask

  // Wait (bounded) for the result strobe after the last pixel was driven.
  task automatic wait_result(input string tag);
    int n, nbusy;
    bit seen, moved;
    logic [2:0] hx, hy;
    logic hf;
    n = 0; nbusy = 0; seen = 0; moved = 0;
    hx = bx; hy = by; hf = bf;
    while (!seen && n < 40) begin
      @(negedge clk);
      idle_inputs();
      n++;
      if (busy === 1'b1) nbusy++;
      if (rv === 1'b1) seen = 1;
      else if (bx !== hx || by !== hy || bf !== hf) moved = 1;
    end
    chk({tag, "_seen"}, 32'(seen), 32'd1);
    chk({tag, "_latency"}, 32'(n), 32'(LAT));
    chk({tag, "_busy_cycles"}, 32'(nbusy), 32'(DIVC));
    chk({tag, "_stable"}, 32'(moved), 32'd0);
    chk({tag, "_x"}, 32'(bx), 32'(exp_x));
    chk({tag, "_y"}, 32'(by), 32'(exp_y));
    chk({tag, "_found"}, 32'(bf), 32'(exp_f));
    @(negedge clk);
    chk({tag, "_strobe_1cyc"}, 32'(rv), 32'd0);
  endtask

  bit [NPIX-1:0] s1, m;
  int rv_seen;

  initial begin
    rst = 1'b1;
    idle_inputs();
    repeat (3) @(negedge clk);
    chk("reset_x", 32'(bx), 32'd0);
    chk("reset_y", 32'(by), 32'd0);
    chk("reset_found", 32'(bf), 32'd0);
    chk("reset_rv", 32'(rv), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: four-pixel square
    s1 = '0;
    s1[10] = 1'b1; s1[11] = 1'b1; s1[18] = 1'b1; s1[19] = 1'b1;
    model(s1);
    send_pixels(s1, NPIX, 1'b0);
    wait_result("s1");
    chk("s1_spec_x", 32'(bx), 32'd2);
    chk("s1_spec_y", 32'(by), 32'd1);

    // 2: empty frame keeps old centroid
    m = '0;
    model(m);
    send_pixels(m, NPIX, 1'b0);
    wait_result("s2_empty");

    // 3: single match at last pixel, then full frame
    m = '0;
    m[NPIX-1] = 1'b1;
    model(m);
    send_pixels(m, NPIX, 1'b0);
    wait_result("s3_single");
    m = '1;
    model(m);
    send_pixels(m, NPIX, 1'b0);
    wait_result("s3_full");
    chk("s3_spec_x", 32'(bx), 32'd3);
    chk("s3_spec_y", 32'(by), 32'd2);

    // 4: sof restart at (4,3) after ten matches
    m = '0;
    for (int i = 0; i < 10; i++) m[i] = 1'b1;
    send_pixels(m, 3 * H + 4, 1'b0);
    m = '0;
    m[0] = 1'b1; m[1] = 1'b1;
    model(m);
    send_pixels(m, NPIX, 1'b0);
    wait_result("s4_restart");

    // 5: pix_valid toggling with scenario 1 pattern
    model(s1);
    send_pixels(s1, NPIX, 1'b1);
    wait_result("s5_gap");

    // 6: reset four cycles into the division
    model(s1);
    send_pixels(s1, NPIX, 1'b0);
    repeat (4) begin
      @(negedge clk);
      idle_inputs();
    end
    chk("s6_busy_before_rst", 32'(busy), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("s6_rst_x", 32'(bx), 32'd0);
    chk("s6_rst_y", 32'(by), 32'd0);
    chk("s6_rst_found", 32'(bf), 32'd0);
    chk("s6_rst_rv", 32'(rv), 32'd0);
    chk("s6_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    rv_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (rv === 1'b1) rv_seen++;
    end
    chk("s6_no_result", 32'(rv_seen), 32'd0);
    exp_x = 0; exp_y = 0; exp_f = 0;
    model(s1);
    send_pixels(s1, NPIX, 1'b0);
    wait_result("s6_after");

    // Randomized frames against the model
    for (int k = 0; k < 6; k++) begin
      if (k == 2) begin
        m = '0;
        m[$urandom_range(NPIX - 1, 0)] = 1'b1;
      end else begin
        m = {$urandom, $urandom} & {$urandom, $urandom};
      end
      model(m);
      send_pixels(m, NPIX, 1'($urandom_range(1, 0)));
      wait_result($sformatf("rand%0d", k));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
